// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: one-entry holding register feeding a shift
// register that emits one bit per bit_en strobe, with frame markers and optional gap.
module piso_serializer #(
  parameter int WIDTH     = 12,
  parameter bit MSB_FIRST = 1'b0,
  parameter int GAP_BITS  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             bit_en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy,
  output logic [WIDTH-1:0] shreg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [7:0]    GAP_LAST = 8'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);
  localparam bit            HAS_GAP  = (GAP_BITS > 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic [CW-1:0]    bit_cnt;
  logic [7:0]       gap_cnt;

  logic             accept;
  logic             last_bit;
  logic             load;
  logic             out_bit;
  logic [WIDTH-1:0] shifted;

  assign in_ready = !hold_valid;
  assign busy     = (state != ST_IDLE) || hold_valid;
  assign accept   = in_valid && !hold_valid;
  assign last_bit = (bit_cnt == LAST_BIT);

  // Two load points: from IDLE, or chained on the final strobe of a frame when
  // no gap is configured so back-to-back words stream without a bubble.
  always_comb begin
    load = 1'b0;
    if (hold_valid) begin
      if (state == ST_IDLE)
        load = 1'b1;
      else if ((state == ST_SHIFT) && bit_en && last_bit && !HAS_GAP)
        load = 1'b1;
    end
  end

  always_comb begin
    if (MSB_FIRST) begin
      out_bit = shreg[WIDTH-1];
      shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      out_bit = shreg[0];
      shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      hold         <= '0;
      hold_valid   <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_last   <= 1'b0;
    end else if (clr) begin
      state        <= ST_IDLE;
      hold         <= '0;
      hold_valid   <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_last   <= 1'b0;
    end else begin
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_last   <= 1'b0;

      if (accept) begin
        hold       <= in_data;
        hold_valid <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (hold_valid) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bit_en) begin
            serial_out   <= out_bit;
            serial_valid <= 1'b1;
            frame_start  <= (bit_cnt == '0);
            frame_last   <= last_bit;
            shreg        <= shifted;
            bit_cnt      <= bit_cnt + 1'b1;
            if (last_bit) begin
              if (HAS_GAP) begin
                state   <= ST_GAP;
                gap_cnt <= '0;
              end else if (!hold_valid) begin
                state <= ST_IDLE;
              end
            end
          end
        end
        ST_GAP: begin
          if (bit_en) begin
            gap_cnt <= gap_cnt + 1'b1;
            if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Placed after the state update so a chained load overrides the shift.
      if (load) begin
        shreg      <= hold;
        bit_cnt    <= '0;
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB/MSB ordering, back-to-back streaming,
// inter-frame gap, async reset mid-frame and synchronous clear.
module tb_piso_serializer;

  logic        clk = 1'b0;
  logic        rst_n, clr, bit_en, in_valid;
  logic [11:0] in_data;

  logic        l_ready, l_sout, l_sv, l_fs, l_fl, l_busy;
  logic [11:0] l_shreg;
  logic        m_ready, m_sout, m_sv, m_fs, m_fl, m_busy;
  logic [11:0] m_shreg;
  logic        g_ready, g_sout, g_sv, g_fs, g_fl, g_busy;
  logic [11:0] g_shreg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(12), .MSB_FIRST(1'b0), .GAP_BITS(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_en(bit_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(l_ready), .serial_out(l_sout), .serial_valid(l_sv),
    .frame_start(l_fs), .frame_last(l_fl), .busy(l_busy), .shreg(l_shreg));

  piso_serializer #(.WIDTH(12), .MSB_FIRST(1'b1), .GAP_BITS(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_en(bit_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(m_ready), .serial_out(m_sout), .serial_valid(m_sv),
    .frame_start(m_fs), .frame_last(m_fl), .busy(m_busy), .shreg(m_shreg));

  piso_serializer #(.WIDTH(12), .MSB_FIRST(1'b0), .GAP_BITS(3)) u_gap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_en(bit_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(g_ready), .serial_out(g_sout), .serial_valid(g_sv),
    .frame_start(g_fs), .frame_last(g_fl), .busy(g_busy), .shreg(g_shreg));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    clr = 1'b1; bit_en = 1'b0; in_valid = 1'b0;
    step();
    clr = 1'b0;
  endtask

  initial begin
    logic [11:0] w0, w1, wexp;
    int bad, words_sent, frames_seen, gap_strobes, busy_bad, k, cyc;
    logic between, rdy_pre, be_now;

    rst_n = 1'b0; clr = 1'b0; bit_en = 1'b0; in_valid = 1'b0; in_data = '0;
    step(); step();
    chk("rst_ready", l_ready, 1'b1);
    chk("rst_busy",  l_busy, 1'b0);
    chk("rst_sv",    l_sv, 1'b0);
    chk("rst_sout",  l_sout, 1'b0);
    chk("rst_shreg", l_shreg, 12'h000);
    rst_n = 1'b1;
    step();

    // async reset after the 5th bit of 0xFFF
    in_valid = 1'b1; in_data = 12'hFFF;
    step();                       // accept
    in_valid = 1'b0; bit_en = 1'b1;
    step();                       // load
    for (int i = 0; i < 5; i++) step();
    chk("mid_sv5",   l_sv, 1'b1);
    chk("mid_bit5",  l_sout, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sout",  l_sout, 1'b0);
    chk("mid_rst_sv",    l_sv, 1'b0);
    chk("mid_rst_fs",    l_fs, 1'b0);
    chk("mid_rst_fl",    l_fl, 1'b0);
    chk("mid_rst_ready", l_ready, 1'b1);
    chk("mid_rst_busy",  l_busy, 1'b0);
    chk("mid_rst_shreg", l_shreg, 12'h000);
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (l_sv !== 1'b0 || m_sv !== 1'b0 || g_sv !== 1'b0) bad++;
    end
    chk("no_residual", bad, 0);

    // single word 0xA5C, bit_en constant: LSB, MSB and gap instances in parallel
    clear_all();
    w0 = 12'hA5C;
    in_valid = 1'b1; in_data = w0; bit_en = 1'b1;
    step();                       // accept
    in_valid = 1'b0;
    chk("a5c_ready_low", l_ready, 1'b0);
    step();                       // load
    chk("a5c_sv_before", l_sv, 1'b0);
    chk("a5c_shreg_load", l_shreg, 12'hA5C);
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("lsb_sv%0d", i),  l_sv, 1'b1);
      chk($sformatf("lsb_bit%0d", i), l_sout, w0[i]);
      chk($sformatf("lsb_fs%0d", i),  l_fs, (i == 0));
      chk($sformatf("lsb_fl%0d", i),  l_fl, (i == 11));
      chk($sformatf("msb_bit%0d", i), m_sout, w0[11-i]);
      chk($sformatf("msb_fs%0d", i),  m_fs, (i == 0));
      chk($sformatf("msb_fl%0d", i),  m_fl, (i == 11));
    end
    chk("lsb_shreg_end", l_shreg, 12'h000);
    chk("msb_shreg_end", m_shreg, 12'h000);
    chk("lsb_busy_end",  l_busy, 1'b0);
    chk("gap_busy_end",  g_busy, 1'b1);
    step();
    chk("lsb_sv_after",  l_sv, 1'b0);
    chk("lsb_sout_hold", l_sout, 1'b1);

    // back-to-back 0x001 then 0x800, no bubble
    clear_all();
    bit_en = 1'b1; in_valid = 1'b1; in_data = 12'h001;
    step();                       // accept word 1
    chk("b2b_ready_full", l_ready, 1'b0);
    in_data = 12'h800;
    step();                       // load word 1
    chk("b2b_ready_empty", l_ready, 1'b1);
    for (int i = 0; i < 24; i++) begin
      step();
      if (i == 0) begin
        in_valid = 1'b0;
        chk("b2b_ready_held", l_ready, 1'b0);
      end
      chk($sformatf("b2b_sv%0d", i),  l_sv, 1'b1);
      chk($sformatf("b2b_bit%0d", i), l_sout, (i == 0 || i == 23));
      chk($sformatf("b2b_fs%0d", i),  l_fs, (i == 0 || i == 12));
      chk($sformatf("b2b_fl%0d", i),  l_fl, (i == 11 || i == 23));
    end
    step();
    chk("b2b_sv_end", l_sv, 1'b0);

    // GAP_BITS=3 with bit_en every 4th cycle, two words
    clear_all();
    w0 = 12'h123; w1 = 12'h456;
    words_sent = 0; frames_seen = 0; gap_strobes = 0; busy_bad = 0; k = 0;
    between = 1'b0; bad = 0;
    in_valid = 1'b1; in_data = w0;
    cyc = 0;
    while (cyc < 400 && frames_seen < 2) begin
      be_now = (cyc % 4 == 3);
      bit_en = be_now;
      rdy_pre = g_ready;
      step();
      if (in_valid && rdy_pre) begin
        words_sent++;
        if (words_sent == 2) in_valid = 1'b0;
        else in_data = w1;
      end
      if (words_sent >= 1 && g_busy !== 1'b1) busy_bad++;
      if (g_sv === 1'b1) begin
        wexp = (k < 12) ? w0 : w1;
        if (g_sout !== wexp[k % 12]) bad++;
        if (g_fs === 1'b1) between = 1'b0;
        k++;
      end else if (between && be_now) begin
        gap_strobes++;
      end
      if (g_fl === 1'b1) begin
        frames_seen++;
        between = 1'b1;
      end
      cyc++;
    end
    chk("gap_frames",  frames_seen, 2);
    chk("gap_bits",    k, 24);
    chk("gap_data",    bad, 0);
    chk("gap_strobes", gap_strobes, 3);
    chk("gap_busy",    busy_bad, 0);

    // clr while shifting with the hold full
    clear_all();
    bit_en = 1'b1; in_valid = 1'b1; in_data = 12'hFFF;
    step();                       // accept A
    in_data = 12'h0F0;
    step();                       // load A
    step();                       // accept B, bit 0 of A
    in_valid = 1'b0;
    chk("clr_hold_full", l_ready, 1'b0);
    chk("clr_busy_pre",  l_busy, 1'b1);
    step(); step();
    clr = 1'b1;
    step();
    chk("clr_ready", l_ready, 1'b1);
    chk("clr_busy",  l_busy, 1'b0);
    chk("clr_sv",    l_sv, 1'b0);
    chk("clr_sout",  l_sout, 1'b0);
    chk("clr_shreg", l_shreg, 12'h000);
    clr = 1'b0; in_valid = 1'b1; in_data = 12'h3C1;
    step();                       // accept C
    in_valid = 1'b0;
    chk("clr_accept_new", l_ready, 1'b0);
    step();                       // load C
    w0 = 12'h3C1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (l_sv !== 1'b1 || l_sout !== w0[i]) bad++;
    end
    chk("clr_new_word", bad, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (l_sv !== 1'b0) bad++;
    end
    chk("clr_no_old_word", bad, 0);
    chk("clr_idle_busy", l_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
